hazard_controller: RTL and testbench

- Pipeline sequencer for the 5-stage RV32I core. Sits beside the decoder and issues stall, flush and bubble controls to the IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards, taken-branch/jump redirects and data-memory wait states.
- Traps and halts on illegal instructions (decoder decode_failed) and on data-memory timeout.
- Keeps saturating performance counters.

---
 rtl/hazard_controller_pkg.sv | 18 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_controller.sv | 159 +++++++++++++++
 tb/tb_hazard_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE        = 2'd0,
        TRAP_ILLEGAL     = 2'd1,
        TRAP_MEM_TIMEOUT = 2'd2
    } trap_cause_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for performance statistics
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/bubble sequencer for the 5-stage RV32I pipeline
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_decode_failed,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             redirect_en,
    output logic             trap_valid,
    output logic [1:0]       trap_cause,
    output logic [31:0]      trap_pc,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT - 1);

    hazard_state_t state, state_nxt;
    logic [7:0]    wait_cnt, wait_cnt_nxt;
    trap_cause_t   cause_q, cause_nxt;
    logic [31:0]   trap_pc_q, trap_pc_nxt;
    logic          trap_valid_q, trap_valid_nxt;

    logic mem_wait;
    logic load_use;
    logic illegal;

    assign mem_wait = dmem_req && !dmem_ready;
    assign load_use = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign illegal  = id_valid && id_decode_failed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            cause_q      <= TRAP_NONE;
            trap_pc_q    <= '0;
            trap_valid_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            cause_q      <= cause_nxt;
            trap_pc_q    <= trap_pc_nxt;
            trap_valid_q <= trap_valid_nxt;
        end
    end

    always_comb begin
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        stall_mem      = 1'b0;
        flush_id       = 1'b0;
        bubble_ex      = 1'b0;
        redirect_en    = 1'b0;
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        cause_nxt      = cause_q;
        trap_pc_nxt    = trap_pc_q;
        trap_valid_nxt = 1'b0;

        case (state)
            HALT: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
            end
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    // EX is frozen, so any redirect waits until the memory releases
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    if (state == RUN) begin
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = 8'd1;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state_nxt      = HALT;
                        trap_valid_nxt = 1'b1;
                        cause_nxt      = TRAP_MEM_TIMEOUT;
                        trap_pc_nxt    = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    if (ex_redirect) begin
                        // the redirect squashes ID, hiding any hazard or illegal op there
                        flush_id    = 1'b1;
                        bubble_ex   = 1'b1;
                        redirect_en = 1'b1;
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (illegal) begin
                        stall_if       = 1'b1;
                        stall_id       = 1'b1;
                        bubble_ex      = 1'b1;
                        state_nxt      = HALT;
                        trap_valid_nxt = 1'b1;
                        cause_nxt      = TRAP_ILLEGAL;
                        trap_pc_nxt    = id_pc;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign trap_valid = trap_valid_q;
    assign trap_cause = cause_q;
    assign trap_pc    = trap_pc_q;
    assign halted     = (state == HALT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_if && (state != HALT)),
        .count   (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_id),
        .count   (flush_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed scoreboard bench for hazard_controller
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_decode_failed;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_valid, ex_mem_read, ex_redirect, dmem_req, dmem_ready;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, bubble_ex, redirect_en, trap_valid, halted;
    logic [1:0]  trap_cause;
    logic [31:0] trap_pc, stall_cycles, flush_count;

    hazard_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .id_decode_failed (id_decode_failed),
        .ex_valid         (ex_valid),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .ex_redirect      (ex_redirect),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .stall_if         (stall_if),
        .stall_id         (stall_id),
        .stall_ex         (stall_ex),
        .stall_mem        (stall_mem),
        .flush_id         (flush_id),
        .bubble_ex        (bubble_ex),
        .redirect_en      (redirect_en),
        .trap_valid       (trap_valid),
        .trap_cause       (trap_cause),
        .trap_pc          (trap_pc),
        .halted           (halted),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, redirect_en}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_ALL  = 7'b1111000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_RD   = 7'b0000111;

    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic        hlt;
        logic        tv;
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_sc = 0;
    logic [31:0] exp_fc = 0;

    task automatic idle_in();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_decode_failed = 0;
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0; ex_redirect = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic check_out();
        exp_t       e;
        logic [6:0] ctl_obs;
        logic [3:0] st_obs;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            ctl_obs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, redirect_en};
            st_obs  = {halted, trap_valid, trap_cause};
            checks++;
            assert (ctl_obs === e.ctl) else begin
                failures++;
                $error("FAIL %s.ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
            end
            checks++;
            assert (st_obs === {e.hlt, e.tv, e.cause}) else begin
                failures++;
                $error("FAIL %s.status observed=%b expected=%b", e.tag, st_obs, {e.hlt, e.tv, e.cause});
            end
            checks++;
            assert (trap_pc === e.pc) else begin
                failures++;
                $error("FAIL %s.trap_pc observed=%h expected=%h", e.tag, trap_pc, e.pc);
            end
            checks++;
            assert (stall_cycles === e.sc) else begin
                failures++;
                $error("FAIL %s.stall_cycles observed=%0d expected=%0d", e.tag, stall_cycles, e.sc);
            end
            checks++;
            assert (flush_count === e.fc) else begin
                failures++;
                $error("FAIL %s.flush_count observed=%0d expected=%0d", e.tag, flush_count, e.fc);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic [6:0] ctl, input logic hlt,
                       input logic tv, input logic [1:0] cause, input logic [31:0] pc);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.hlt = hlt; e.tv = tv;
        e.cause = cause; e.pc = pc; e.sc = exp_sc; e.fc = exp_fc;
        sb.push_back(e);
        @(negedge clk);
        check_out();
        if (ctl[6] && !hlt) exp_sc++;
        if (ctl[2]) exp_fc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_in();
        @(posedge clk);
        #1;
        reset_n = 1;
        exp_sc = 0;
        exp_fc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        idle_in();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1;
        cyc("reset", C_NONE, 0, 0, 0, 0);

        ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1;
        cyc("lu_rs1", C_LU, 0, 0, 0, 0);
        idle_in();
        cyc("lu_clear", C_NONE, 0, 0, 0, 0);

        ex_valid = 1; ex_mem_read = 1; ex_rd = 0;
        id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1;
        cyc("lu_x0", C_NONE, 0, 0, 0, 0);

        ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 1;
        cyc("lu_rs2", C_LU, 0, 0, 0, 0);
        id_uses_rs2 = 0;
        cyc("lu_rs2_unused", C_NONE, 0, 0, 0, 0);

        ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_redirect = 1;
        cyc("redirect_lu", C_RD, 0, 0, 0, 0);
        idle_in();
        cyc("redirect_after", C_NONE, 0, 0, 0, 0);

        dmem_req = 1; dmem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 5; i++) cyc("memwait5", C_ALL, 0, 0, 0, 0);
        dmem_ready = 1;
        cyc("memwait5_release", C_RD, 0, 0, 0, 0);
        idle_in();
        cyc("memwait5_idle", C_NONE, 0, 0, 0, 0);

        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 15; i++) cyc("ready16_wait", C_ALL, 0, 0, 0, 0);
        dmem_ready = 1;
        cyc("ready16_release", C_NONE, 0, 0, 0, 0);
        idle_in();
        cyc("ready16_notrap", C_NONE, 0, 0, 0, 0);

        id_valid = 1; id_decode_failed = 1; id_pc = 32'h0000_0040; ex_redirect = 1;
        cyc("illegal_redirect", C_RD, 0, 0, 0, 0);
        idle_in();
        cyc("illegal_redirect_notrap", C_NONE, 0, 0, 0, 0);

        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 16; i++) cyc("timeout_wait", C_ALL, 0, 0, 0, 0);
        cyc("timeout_trap", C_ALL, 1, 1, 2, 0);
        idle_in();
        ex_redirect = 1; id_valid = 1; id_decode_failed = 1; id_pc = 32'h1234;
        cyc("timeout_halt", C_ALL, 1, 0, 2, 0);
        cyc("timeout_halt2", C_ALL, 1, 0, 2, 0);

        do_reset();
        cyc("halt_reset", C_NONE, 0, 0, 0, 0);

        id_valid = 1; id_decode_failed = 1; id_pc = 32'h0000_0040;
        cyc("illegal", C_LU, 0, 0, 0, 0);
        idle_in();
        cyc("illegal_trap", C_ALL, 1, 1, 1, 32'h40);
        cyc("illegal_halt", C_ALL, 1, 0, 1, 32'h40);

        do_reset();
        cyc("illegal_reset", C_NONE, 0, 0, 0, 0);

        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) cyc("memwait_pre_reset", C_ALL, 0, 0, 0, 0);
        do_reset();
        cyc("memwait_reset", C_NONE, 0, 0, 0, 0);
        cyc("memwait_reset_idle", C_NONE, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
